// File: rtl/uart_word_tx_buffer.sv
// uart_word_tx_buffer: FIFO of 32-bit words serialised MSB-first into bytes for a ready/enable UART byte sender
module uart_word_tx_buffer #(
  parameter int ADDR_WIDTH = 4,
  parameter int SEND_BYTES = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [31:0]           word_data,
  input  logic                  word_push,
  input  logic                  sender_ready,
  output logic [7:0]            sender_data,
  output logic                  sender_enable,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  busy,
  output logic                  overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [31:0]           shift;
  logic [1:0]            idx;
  logic [2:0]            gap_cnt;
  logic                  push_ok, pop;
  logic [ADDR_WIDTH:0]   count_nxt;
  // full is the registered flag, so a push in the same cycle as a pop from a full FIFO is still dropped
  assign push_ok   = word_push & ~fifo_full;
  assign pop       = (state == IDLE) & ~fifo_empty;
  assign count_nxt = fifo_count + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop);
  assign busy      = (state != IDLE) | ~fifo_empty;
  always_ff @(posedge CLK)
    if (push_ok) mem[wr_ptr] <= word_data;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_full     <= 1'b0;
      fifo_empty    <= 1'b1;
      overflow      <= 1'b0;
      shift         <= '0;
      idx           <= '0;
      gap_cnt       <= '0;
      sender_data   <= '0;
      sender_enable <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (word_push & fifo_full) overflow <= 1'b1;
      fifo_count    <= count_nxt;
      fifo_full     <= count_nxt == (ADDR_WIDTH+1)'(DEPTH);
      fifo_empty    <= count_nxt == '0;
      sender_enable <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          shift <= mem[rd_ptr];
          idx   <= 2'(SEND_BYTES - 1);
          state <= SEND;
        end
        SEND: if (sender_ready) begin
          sender_data   <= shift[{idx, 3'b000} +: 8];
          sender_enable <= 1'b1;
          gap_cnt       <= 3'(GAP_CYCLES);
          state         <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == 3'd1) begin
            if (idx == 2'd0) state <= IDLE;
            else begin
              idx   <= idx - 1'b1;
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_tx_buffer.sv
// tb_uart_word_tx_buffer: vector table plus byte scoreboard for the word-to-byte UART transmit buffer
module tb_uart_word_tx_buffer;
  logic        CLK = 0, reset;
  logic [31:0] word_data, data1;
  logic        word_push, sender_ready, push1, ready1;
  logic [7:0]  sender_data, sdata1;
  logic        sender_enable, fifo_full, fifo_empty, busy, overflow;
  logic        en1, full1, empty1, busy1, ovf1;
  logic [4:0]  fifo_count, count1;
  logic [7:0]  exp_q[$];
  logic        prev_en = 0;
  int          tests = 0, fails = 0;

  always #5 CLK = ~CLK;

  uart_word_tx_buffer #(.ADDR_WIDTH(4), .SEND_BYTES(4), .GAP_CYCLES(2)) dut (
    .CLK(CLK), .reset(reset), .word_data(word_data), .word_push(word_push),
    .sender_ready(sender_ready), .sender_data(sender_data), .sender_enable(sender_enable),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .busy(busy), .overflow(overflow));

  uart_word_tx_buffer #(.ADDR_WIDTH(4), .SEND_BYTES(1), .GAP_CYCLES(2)) dut1 (
    .CLK(CLK), .reset(reset), .word_data(data1), .word_push(push1),
    .sender_ready(ready1), .sender_data(sdata1), .sender_enable(en1),
    .fifo_full(full1), .fifo_empty(empty1), .fifo_count(count1),
    .busy(busy1), .overflow(ovf1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every enable pulse must carry the next expected byte, never two pulses in a row
  always @(negedge CLK) begin
    if (sender_enable) begin
      tests++;
      if (prev_en || exp_q.size() == 0 || sender_data !== exp_q[0]) begin
        fails++;
        $display("FAIL byte_stream: got %0h expected %0h (queued %0d, back_to_back %0b)",
                 sender_data, exp_q.size() ? exp_q[0] : 8'h00, exp_q.size(), prev_en);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    prev_en = sender_enable;
    if (fifo_count > 5'd16) begin
      tests++;
      fails++;
      $display("FAIL count_bound: got %0d expected <= 16", fifo_count);
    end
  end

  task automatic push(input logic [31:0] w, input bit accepted);
    word_data = w;
    word_push = 1;
    if (accepted) for (int k = 3; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
    @(negedge CLK);
    word_push = 0;
  endtask

  task automatic wait_en(input int n);
    int seen = 0, c = 0;
    while (seen < n && c < 500) begin
      @(negedge CLK);
      c++;
      if (sender_enable) seen++;
    end
    check("wait_enables", seen, n);
  endtask

  task automatic drain(input bit rnd);
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      if (rnd) sender_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      c++;
    end
    check("drain_done", exp_q.size(), 0);
    sender_ready = 1;
    repeat (4) @(negedge CLK);
  endtask

  typedef struct {
    logic        push;
    logic [31:0] data;
    logic        en;
    logic [7:0]  sd;
    logic        bsy;
    logic        emp;
  } vec_t;
  vec_t tv[15];

  initial begin
    // row i holds the outputs expected in the cycle after row i's inputs are applied
    for (int i = 0; i < 15; i++)
      tv[i] = '{push: (i == 0), data: 32'h41424344,
                en: (i == 2 || i == 5 || i == 8 || i == 11),
                sd: i < 2 ? 8'h00 : i < 5 ? 8'h41 : i < 8 ? 8'h42 : i < 11 ? 8'h43 : 8'h44,
                bsy: (i < 13), emp: (i != 0)};
    reset = 1; word_push = 0; word_data = 0; sender_ready = 1;
    push1 = 0; data1 = 0; ready1 = 0;
    repeat (2) @(negedge CLK);
    reset = 0;
    check("rst_data", sender_data, 0);
    check("rst_enable", sender_enable, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);

    for (int i = 0; i < 15; i++) begin
      word_push = tv[i].push;
      word_data = tv[i].data;
      if (tv[i].push) for (int k = 3; k >= 0; k--) exp_q.push_back(tv[i].data[8*k +: 8]);
      @(negedge CLK);
      check($sformatf("single_en[%0d]", i), sender_enable, tv[i].en);
      check($sformatf("single_data[%0d]", i), sender_data, tv[i].sd);
      check($sformatf("single_busy[%0d]", i), busy, tv[i].bsy);
      check($sformatf("single_empty[%0d]", i), fifo_empty, tv[i].emp);
    end
    word_push = 0;

    data1 = 32'h000000AA;
    push1 = 1;
    @(negedge CLK);
    push1 = 0;
    for (int i = 0; i < 20; i++) begin
      check("stall_no_enable", en1, 0);
      @(negedge CLK);
    end
    ready1 = 1;
    @(negedge CLK);
    check("stall_enable", en1, 1);
    check("stall_data", sdata1, 8'hAA);
    @(negedge CLK);
    check("stall_single_pulse", en1, 0);
    @(negedge CLK);
    check("stall_idle", busy1, 0);

    // word 0 is popped into the shifter at once, so words 1..16 fill the FIFO and word 17 is dropped
    sender_ready = 0;
    for (int w = 0; w < 17; w++) push(32'(w) * 32'h01010101 + 32'h00010203, 1);
    check("full_flag", fifo_full, 1);
    check("full_count", fifo_count, 16);
    check("full_no_overflow", overflow, 0);
    push(32'h11121314, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_count", fifo_count, 16);
    sender_ready = 1;
    wait_en(4);
    @(negedge CLK);
    @(negedge CLK);
    check("pop_cycle_full", fifo_full, 1);
    push(32'hDEADBEEF, 0);
    check("pushpop_count", fifo_count, 15);
    check("pushpop_full", fifo_full, 0);
    check("pushpop_overflow", overflow, 1);
    drain(0);
    check("drained_busy", busy, 0);
    check("drained_empty", fifo_empty, 1);

    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) begin
        sender_ready = 1'($urandom_range(0, 1));
        push({8'(b * 8 + k), 24'($urandom)}, 1);
      end
      drain(1);
    end
    check("wrap_busy", busy, 0);

    sender_ready = 0;
    for (int w = 0; w < 4; w++) push(32'hA0B0C0D0 + 32'(w), 1);
    sender_ready = 1;
    wait_en(2);
    #1;
    reset = 1;
    exp_q.delete();
    @(negedge CLK);
    reset = 0;
    check("midrst_enable", sender_enable, 0);
    check("midrst_empty", fifo_empty, 1);
    check("midrst_overflow", overflow, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", fifo_count, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("midrst_quiet", sender_enable, 0);
    end
    push(32'h01020304, 1);
    drain(0);
    repeat (20) @(negedge CLK);
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
